alu_op_sequencer: RTL and testbench

Registered, multi-cycle-aware ALU control unit for the single-issue datapath. Decodes `alu_op_i` and `funct_i` into the ALU function code, as the combinational ALU control does, and adds iterative multiply/divide sequencing. The block holds the function code steady while the iterative operation runs and issues a ready/valid handshake toward the pipeline controller. It sits between the main control and the ALU, and drives the stall source for multi-cycle ops.

---
 rtl/alu_ctrl_pkg.sv | 46 ++++
 rtl/alu_func_decode.sv | 84 ++++++++
 rtl/alu_op_sequencer.sv | 162 ++++++++++++++++
 tb/tb_alu_op_sequencer.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_ctrl_pkg
//  Description : Shared constants for the ALU control path: main-control op
//                classes, R-type funct encodings, ALU function codes and the
//                sequencer state encoding.
//  Config      : ALU_SEQ_DIV_EN (consumed by alu_func_decode) enables the
//                iterative divide.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_ctrl_pkg;

   // Main-control ALU op classes
   localparam logic [1:0] ALU_OP_ADD   = 2'b00;   // loads/stores: address add
   localparam logic [1:0] ALU_OP_SUB   = 2'b01;   // branches: compare by subtract
   localparam logic [1:0] ALU_OP_RTYPE = 2'b10;   // decode the funct field
   localparam logic [1:0] ALU_OP_RSVD  = 2'b11;   // reserved, always illegal

   // R-type funct field encodings
   localparam logic [5:0] FUNCT_SUB = 6'b001011;
   localparam logic [5:0] FUNCT_ADD = 6'b001101;
   localparam logic [5:0] FUNCT_AND = 6'b010010;
   localparam logic [5:0] FUNCT_OR  = 6'b100110;
   localparam logic [5:0] FUNCT_MUL = 6'b011000;
   localparam logic [5:0] FUNCT_DIV = 6'b011010;

   // ALU function codes
   localparam logic [5:0] FUNC_NOP = 6'b000000;
   localparam logic [5:0] FUNC_SUB = 6'b001001;
   localparam logic [5:0] FUNC_ADD = 6'b001010;
   localparam logic [5:0] FUNC_AND = 6'b010001;
   localparam logic [5:0] FUNC_OR  = 6'b100001;
   localparam logic [5:0] FUNC_MUL = 6'b011000;
   localparam logic [5:0] FUNC_DIV = 6'b011010;

   // Cycle-count width: iterative ops may take up to 256 cycles
   localparam int CYC_W = 9;

   // Sequencer state encoding
   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_e;

endpackage : alu_ctrl_pkg
`default_nettype wire

// File: rtl/alu_func_decode.sv
`default_nettype none
// ============================================================================
//  Module      : alu_func_decode
//  Description : Combinational ALU-control decoder. Maps the main-control op
//                class and funct field to an ALU function code and reports
//                whether the op is iterative, how many cycles it takes and
//                whether the request is undecodable.
//  Config      : ALU_SEQ_DIV_EN defined   -> divide is an iterative op of
//                                            DIV_CYCLES cycles.
//                ALU_SEQ_DIV_EN undefined -> divide decodes as illegal.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_func_decode
   import alu_ctrl_pkg::*;
#(
   parameter int FUNC_W     = 6,
   parameter int MUL_CYCLES = 4,
   parameter int DIV_CYCLES = 8
) (
   input  logic [1:0]        alu_op,
   input  logic [FUNC_W-1:0] funct,
   output logic [FUNC_W-1:0] func,
   output logic              is_multi,
   output logic [CYC_W-1:0]  cycles,
   output logic              illegal
);

`ifdef ALU_SEQ_DIV_EN
   localparam bit c_div_en = 1'b1;
`else
   localparam bit c_div_en = 1'b0;
`endif

   // Encodings resized to the configured funct width
   localparam logic [FUNC_W-1:0] c_ft_sub = FUNC_W'(FUNCT_SUB);
   localparam logic [FUNC_W-1:0] c_ft_add = FUNC_W'(FUNCT_ADD);
   localparam logic [FUNC_W-1:0] c_ft_and = FUNC_W'(FUNCT_AND);
   localparam logic [FUNC_W-1:0] c_ft_or  = FUNC_W'(FUNCT_OR);
   localparam logic [FUNC_W-1:0] c_ft_mul = FUNC_W'(FUNCT_MUL);
   localparam logic [FUNC_W-1:0] c_ft_div = FUNC_W'(FUNCT_DIV);

   localparam logic [CYC_W-1:0]  c_one_cyc = CYC_W'(1);
   localparam logic [CYC_W-1:0]  c_mul_cyc = CYC_W'(MUL_CYCLES);
   localparam logic [CYC_W-1:0]  c_div_cyc = CYC_W'(DIV_CYCLES);

   // Decode table; anything not listed falls through to NOP + illegal
   always_comb begin
      func     = FUNC_W'(FUNC_NOP);
      is_multi = 1'b0;
      cycles   = c_one_cyc;
      illegal  = 1'b0;
      case (alu_op)
         ALU_OP_ADD: func = FUNC_W'(FUNC_ADD);
         ALU_OP_SUB: func = FUNC_W'(FUNC_SUB);
         ALU_OP_RTYPE: begin
            case (funct)
               c_ft_sub: func = FUNC_W'(FUNC_SUB);
               c_ft_add: func = FUNC_W'(FUNC_ADD);
               c_ft_and: func = FUNC_W'(FUNC_AND);
               c_ft_or:  func = FUNC_W'(FUNC_OR);
               c_ft_mul: begin
                  func     = FUNC_W'(FUNC_MUL);
                  is_multi = 1'b1;
                  cycles   = c_mul_cyc;
               end
               c_ft_div: begin
                  // Divider hardware is optional; without it divide is undecodable
                  if (c_div_en) begin
                     func     = FUNC_W'(FUNC_DIV);
                     is_multi = 1'b1;
                     cycles   = c_div_cyc;
                  end else begin
                     illegal  = 1'b1;
                  end
               end
               default:  illegal = 1'b1;
            endcase
         end
         default: illegal = 1'b1;   // ALU_OP_RSVD
      endcase
   end

endmodule : alu_func_decode
`default_nettype wire

// File: rtl/alu_op_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : alu_op_sequencer
//  Description : Registered ALU control unit with iterative multiply/divide
//                sequencing. Holds the function code steady while an
//                iterative op runs, counts down its remaining iterations and
//                signals completion with a one-cycle out_valid_o pulse.
//                ready_o depends on state only.
//  Config      : ALU_SEQ_DIV_EN enables the iterative divide (see
//                alu_func_decode); multiply is always present.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_op_sequencer
   import alu_ctrl_pkg::*;
#(
   parameter int FUNC_W     = 6,
   parameter int MUL_CYCLES = 4,
   parameter int DIV_CYCLES = 8,
   parameter int CNT_W      = 8
) (
   input  logic              clk_i,
   input  logic              rst_i,        // asynchronous, active-low
   input  logic              valid_i,
   output logic              ready_o,
   input  logic [1:0]        alu_op_i,
   input  logic [FUNC_W-1:0] funct_i,
   input  logic              flush_i,
   output logic [FUNC_W-1:0] func_o,
   output logic              multi_o,
   output logic              out_valid_o,
   output logic              illegal_o,
   output logic [CNT_W-1:0]  cnt_o
);

   localparam logic [0:0] S_IDLE = 1'(ST_IDLE);
   localparam logic [0:0] S_BUSY = 1'(ST_BUSY);

   localparam logic [CYC_W-1:0] c_cyc_one = CYC_W'(1);
   localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);

   // Registered state
   logic [0:0]        r_state;
   logic [FUNC_W-1:0] r_func;
   logic              r_multi;
   logic              r_out_valid;
   logic              r_illegal;
   logic [CNT_W-1:0]  r_cnt;

   // Decoder outputs
   logic [FUNC_W-1:0] w_dec_func;
   logic              w_dec_multi;
   logic [CYC_W-1:0]  w_dec_cycles;
   logic              w_dec_illegal;

   // Next-state values
   logic [0:0]        w_nxt_state;
   logic [FUNC_W-1:0] w_nxt_func;
   logic              w_nxt_multi;
   logic              w_nxt_out_valid;
   logic              w_nxt_illegal;
   logic [CNT_W-1:0]  w_nxt_cnt;

   logic              w_goes_busy;
   logic [CNT_W-1:0]  w_load_cnt;

   alu_func_decode #(
      .FUNC_W     (FUNC_W),
      .MUL_CYCLES (MUL_CYCLES),
      .DIV_CYCLES (DIV_CYCLES)
   ) u_decode (
      .alu_op   (alu_op_i),
      .funct    (funct_i),
      .func     (w_dec_func),
      .is_multi (w_dec_multi),
      .cycles   (w_dec_cycles),
      .illegal  (w_dec_illegal)
   );

   // A one-cycle iterative op completes like a single-cycle op and never enters BUSY
   assign w_goes_busy = w_dec_multi && !w_dec_illegal && (w_dec_cycles > c_cyc_one);
   // The accept cycle is the first iteration, so N-1 remain afterwards
   assign w_load_cnt  = CNT_W'(w_dec_cycles - c_cyc_one);

   // FSM transition, countdown and output-value selection; flush overrides all
   always_comb begin
      w_nxt_state     = r_state;
      w_nxt_func      = r_func;
      w_nxt_multi     = r_multi;
      w_nxt_cnt       = r_cnt;
      w_nxt_out_valid = 1'b0;
      w_nxt_illegal   = 1'b0;
      if (flush_i) begin
         w_nxt_state = S_IDLE;
         w_nxt_func  = FUNC_W'(FUNC_NOP);
         w_nxt_multi = 1'b0;
         w_nxt_cnt   = '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (valid_i) begin
                  w_nxt_func    = w_dec_func;
                  w_nxt_illegal = w_dec_illegal;
                  if (w_goes_busy) begin
                     w_nxt_state = S_BUSY;
                     w_nxt_cnt   = w_load_cnt;
                     w_nxt_multi = 1'b1;
                  end else begin
                     w_nxt_out_valid = 1'b1;
                     w_nxt_multi     = 1'b0;
                     w_nxt_cnt       = '0;
                  end
               end
            end
            S_BUSY: begin
               // func_o is held; the <= guard also recovers from a zero count
               if (r_cnt <= c_cnt_one) begin
                  w_nxt_state     = S_IDLE;
                  w_nxt_out_valid = 1'b1;
                  w_nxt_multi     = 1'b0;
                  w_nxt_cnt       = '0;
               end else begin
                  w_nxt_cnt = r_cnt - c_cnt_one;
               end
            end
            default: begin
               w_nxt_state = S_IDLE;
               w_nxt_func  = FUNC_W'(FUNC_NOP);
               w_nxt_multi = 1'b0;
               w_nxt_cnt   = '0;
            end
         endcase
      end
   end

   // State and output registers; reset aborts any op with no completion pulse
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_state     <= S_IDLE;
         r_func      <= FUNC_W'(FUNC_NOP);
         r_multi     <= 1'b0;
         r_out_valid <= 1'b0;
         r_illegal   <= 1'b0;
         r_cnt       <= '0;
      end else begin
         r_state     <= w_nxt_state;
         r_func      <= w_nxt_func;
         r_multi     <= w_nxt_multi;
         r_out_valid <= w_nxt_out_valid;
         r_illegal   <= w_nxt_illegal;
         r_cnt       <= w_nxt_cnt;
      end
   end

   assign ready_o     = (r_state == S_IDLE);
   assign func_o      = r_func;
   assign multi_o     = r_multi;
   assign out_valid_o = r_out_valid;
   assign illegal_o   = r_illegal;
   assign cnt_o       = r_cnt;

endmodule : alu_op_sequencer
`default_nettype wire

// File: tb/tb_alu_op_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_op_sequencer
//  Description : Self-checking bench for alu_op_sequencer. Accepted requests
//                push their expected result and completion cycle onto a
//                scoreboard; a monitor pops and compares on every cycle.
//  Config      : ALU_SEQ_DIV_EN selects the divide expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_op_sequencer;

   localparam int FUNC_W     = 6;
   localparam int MUL_CYCLES = 4;
   localparam int DIV_CYCLES = 8;
   localparam int CNT_W      = 8;

   logic              clk_i = 1'b0;
   logic              rst_i;
   logic              valid_i;
   logic              flush_i;
   logic [1:0]        alu_op_i;
   logic [FUNC_W-1:0] funct_i;
   logic              ready_o;
   logic              multi_o;
   logic              out_valid_o;
   logic              illegal_o;
   logic [FUNC_W-1:0] func_o;
   logic [CNT_W-1:0]  cnt_o;

   typedef struct {
      logic [5:0] func;
      logic       ill;
      int         n;
      int         due;
   } exp_t;

   exp_t sb[$];
   int   cyc    = 0;
   int   checks = 0;
   int   errors = 0;

   alu_op_sequencer #(
      .FUNC_W     (FUNC_W),
      .MUL_CYCLES (MUL_CYCLES),
      .DIV_CYCLES (DIV_CYCLES),
      .CNT_W      (CNT_W)
   ) dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .valid_i     (valid_i),
      .ready_o     (ready_o),
      .alu_op_i    (alu_op_i),
      .funct_i     (funct_i),
      .flush_i     (flush_i),
      .func_o      (func_o),
      .multi_o     (multi_o),
      .out_valid_o (out_valid_o),
      .illegal_o   (illegal_o),
      .cnt_o       (cnt_o)
   );

   always #5 clk_i = ~clk_i;
   always @(posedge clk_i) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference decode table
   function automatic exp_t model(input logic [1:0] op, input logic [5:0] f);
      exp_t e;
      e.func = 6'b000000;
      e.ill  = 1'b0;
      e.n    = 1;
      e.due  = 0;
      case (op)
         2'b00: e.func = 6'b001010;
         2'b01: e.func = 6'b001001;
         2'b10: begin
            case (f)
               6'b001011: e.func = 6'b001001;
               6'b001101: e.func = 6'b001010;
               6'b010010: e.func = 6'b010001;
               6'b100110: e.func = 6'b100001;
               6'b011000: begin e.func = 6'b011000; e.n = MUL_CYCLES; end
               6'b011010: begin
`ifdef ALU_SEQ_DIV_EN
                  e.func = 6'b011010;
                  e.n    = DIV_CYCLES;
`else
                  e.ill  = 1'b1;
`endif
               end
               default: e.ill = 1'b1;
            endcase
         end
         default: e.ill = 1'b1;
      endcase
      return e;
   endfunction

   task automatic tick;
      @(posedge clk_i);
      #1;
   endtask

   // Present a request the bench knows will be accepted at the next edge
   task automatic req(input logic [1:0] op, input logic [5:0] f);
      exp_t e;
      alu_op_i = op;
      funct_i  = f;
      valid_i  = 1'b1;
      e        = model(op, f);
      e.due    = cyc + e.n;
      sb.push_back(e);
   endtask

   // Completion monitor: out_valid_o must pulse exactly on each due cycle
   logic mon_exp;
   exp_t mon_e;
   always @(posedge clk_i) begin
      #1;
      mon_exp = (sb.size() > 0) && (sb[0].due == cyc);
      chk("out_valid", out_valid_o, mon_exp);
      if (mon_exp) begin
         mon_e = sb.pop_front();
         chk("res_func", func_o, mon_e.func);
         chk("res_illegal", illegal_o, mon_e.ill);
         chk("res_multi", multi_o, 1'b0);
      end else begin
         chk("illegal_idle", illegal_o, 1'b0);
      end
   end

   initial begin
      #20000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   logic [1:0] ops [6] = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b00, 2'b01};
   logic [5:0] fns [6] = '{6'b001101, 6'b001011, 6'b010010, 6'b100110, 6'b111111, 6'b000000};

   initial begin
      rst_i    = 1'b0;
      valid_i  = 1'b0;
      flush_i  = 1'b0;
      alu_op_i = 2'b00;
      funct_i  = '0;
      repeat (2) tick;
      chk("rst_func", func_o, 6'b000000);
      chk("rst_out_valid", out_valid_o, 1'b0);
      chk("rst_cnt", cnt_o, 8'd0);
      chk("rst_multi", multi_o, 1'b0);
      chk("rst_illegal", illegal_o, 1'b0);
      rst_i = 1'b1;
      tick;
      chk("rst_ready", ready_o, 1'b1);

      // Back-to-back single-cycle ops
      for (int i = 0; i < 6; i++) begin
         req(ops[i], fns[i]);
         tick;
         chk("single_ready", ready_o, 1'b1);
      end
      valid_i = 1'b0;
      tick;

      // Multiply with an ignored request while busy, then back-to-back accept
      req(2'b10, 6'b011000);
      tick;
      chk("mul_multi", multi_o, 1'b1);
      chk("mul_cnt3", cnt_o, 8'd3);
      chk("mul_ready", ready_o, 1'b0);
      chk("mul_func", func_o, 6'b011000);
      alu_op_i = 2'b00;
      funct_i  = '0;
      valid_i  = 1'b1;
      tick;
      chk("mul_cnt2", cnt_o, 8'd2);
      chk("mul_func_held", func_o, 6'b011000);
      chk("mul_busy_ready", ready_o, 1'b0);
      tick;
      chk("mul_cnt1", cnt_o, 8'd1);
      tick;
      chk("mul_done_cnt", cnt_o, 8'd0);
      chk("mul_done_ready", ready_o, 1'b1);
      req(2'b00, 6'b000000);
      tick;
      valid_i = 1'b0;
      tick;

      // Illegal requests
      req(2'b11, 6'b001101);
      tick;
      req(2'b10, 6'b111111);
      tick;
      valid_i = 1'b0;
      tick;
      chk("illegal_func_nop", func_o, 6'b000000);

      // Flush mid-multiply
      req(2'b10, 6'b011000);
      tick;
      valid_i = 1'b0;
      tick;
      flush_i = 1'b1;
      sb.delete();
      tick;
      chk("flush_cnt", cnt_o, 8'd0);
      chk("flush_multi", multi_o, 1'b0);
      chk("flush_ready", ready_o, 1'b1);
      chk("flush_func", func_o, 6'b000000);

      // Flush drops a simultaneous request
      alu_op_i = 2'b00;
      valid_i  = 1'b1;
      tick;
      chk("flush_drop_func", func_o, 6'b000000);
      flush_i = 1'b0;
      valid_i = 1'b0;
      tick;

`ifdef ALU_SEQ_DIV_EN
      req(2'b10, 6'b011010);
      tick;
      chk("div_cnt7", cnt_o, 8'd7);
      chk("div_multi", multi_o, 1'b1);
      valid_i = 1'b0;
      repeat (7) tick;
      chk("div_done_ready", ready_o, 1'b1);
      chk("div_done_cnt", cnt_o, 8'd0);
      req(2'b10, 6'b011010);
      tick;
      valid_i = 1'b0;
      tick;
      tick;
      flush_i = 1'b1;
      sb.delete();
      tick;
      chk("div_flush_cnt", cnt_o, 8'd0);
      chk("div_flush_ready", ready_o, 1'b1);
      chk("div_flush_multi", multi_o, 1'b0);
      flush_i = 1'b0;
      repeat (8) tick;
`else
      req(2'b10, 6'b011010);
      tick;
      valid_i = 1'b0;
      chk("div_off_multi", multi_o, 1'b0);
      chk("div_off_ready", ready_o, 1'b1);
      tick;
`endif

      // Asynchronous reset mid-multiply
      req(2'b10, 6'b011000);
      tick;
      valid_i = 1'b0;
      tick;
      rst_i = 1'b0;
      sb.delete();
      #1;
      chk("arst_func", func_o, 6'b000000);
      chk("arst_cnt", cnt_o, 8'd0);
      chk("arst_multi", multi_o, 1'b0);
      chk("arst_out_valid", out_valid_o, 1'b0);
      tick;
      rst_i = 1'b1;
      repeat (6) tick;
      chk("arst_ready", ready_o, 1'b1);

      repeat (2) tick;
      chk("sb_drained", sb.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_alu_op_sequencer
`default_nettype wire
